// File: rtl/sap1_prog_ram.sv
// sap1_prog_ram: SAP-1 16x8 RAM; MAR read port (load/bus -> out) plus a checksummed valid/ready loader (prog_*).
module sap1_prog_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] out,
  input  logic             prog_start,
  input  logic             prog_abort,
  input  logic             prog_valid,
  input  logic [WIDTH-1:0] prog_data,
  output logic             prog_ready,
  output logic             prog_busy,
  output logic             prog_done,
  output logic             prog_err
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t state, state_n;
  logic [3:0] mar, waddr;
  logic [WIDTH-1:0] sum;
  logic xfer, we, start, abort;
  logic [WIDTH-1:0] ram [DEPTH] = '{8'h0D, 8'h1E, 8'h2F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04, 8'h02};
  always_comb begin
    prog_busy  = state != IDLE;
    prog_ready = prog_busy;
    xfer       = prog_valid & prog_ready;
    start      = state == IDLE & prog_start;
    abort      = prog_busy & prog_abort;
    we         = state == DATA & xfer & !prog_abort;
    state_n    = start ? DATA :
                 abort ? IDLE :
                 (we & waddr == 4'(DEPTH - 1)) ? CHECK :
                 (state == CHECK & xfer) ? IDLE : state;
    out        = ram[mar];
  end
  always_ff @(posedge clk)
    if (we) ram[waddr] <= prog_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mar       <= '0;
      waddr     <= '0;
      sum       <= '0;
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (load & !prog_busy) mar <= bus[3:0];
      if (start) begin
        waddr     <= '0;
        sum       <= '0;
        prog_done <= 1'b0;
        prog_err  <= 1'b0;
      end else if (abort) begin
        prog_done <= 1'b0;
        prog_err  <= 1'b1;
      end else if (we) begin
        waddr <= waddr + 4'd1;
        sum   <= sum + prog_data;
      end else if (state == CHECK & xfer) begin
        prog_done <= 1'b1;
        prog_err  <= prog_data != sum;
      end
    end
  end
endmodule

// File: tb/tb_sap1_prog_ram.sv
// tb_sap1_prog_ram: randomized and directed checks of sap1_prog_ram against a frame-level reference model
module tb_sap1_prog_ram;
  logic clk = 0, rst = 1, load = 0, prog_start = 0, prog_abort = 0, prog_valid = 0;
  logic [7:0] bus = 0, prog_data = 0, out;
  logic prog_ready, prog_busy, prog_done, prog_err;
  int compared = 0, mismatched = 0;

  sap1_prog_ram dut (
    .clk(clk), .rst(rst), .load(load), .bus(bus), .out(out),
    .prog_start(prog_start), .prog_abort(prog_abort), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_ready(prog_ready), .prog_busy(prog_busy),
    .prog_done(prog_done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  logic [7:0] m_mem [16] = '{8'h0D, 8'h1E, 8'h2F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h04, 8'h02};
  logic [7:0] q[$];
  logic [3:0] m_mar = 0;
  bit m_active = 0, m_done = 0, m_err = 0, m_init = 0;

  function automatic logic [7:0] qsum();
    logic [7:0] s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_active = 0; m_done = 0; m_err = 0; m_mar = 0; q.delete();
    end else begin
      if (load && !m_active) m_mar = bus[3:0];
      if (!m_active) begin
        if (prog_start) begin m_active = 1; m_done = 0; m_err = 0; q.delete(); end
      end else if (prog_abort) begin
        m_active = 0; m_err = 1; m_done = 0;
      end else if (prog_valid) begin
        if (q.size() < 16) begin
          m_mem[q.size()] = prog_data;
          q.push_back(prog_data);
        end else begin
          m_err = prog_data != qsum(); m_done = 1; m_active = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (m_init) begin
    chk("model_out", out, m_mem[m_mar]);
    chk("model_busy", {7'd0, prog_busy}, {7'd0, m_active});
    chk("model_ready", {7'd0, prog_ready}, {7'd0, m_active});
    chk("model_done", {7'd0, prog_done}, {7'd0, m_done});
    chk("model_err", {7'd0, prog_err}, {7'd0, m_err});
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic clr();
    load = 0; prog_start = 0; prog_abort = 0; prog_valid = 0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    load = 1; bus = {4'h0, a}; cyc(); load = 0; bus = 8'hA5;
    chk(name, out, exp);
  endtask

  task automatic frame(input logic [7:0] d [16], input logic [7:0] ck, input int gap_pct);
    int i = 0;
    prog_start = 1; cyc(); prog_start = 0;
    while (i < 17) begin
      prog_valid = $urandom_range(99) >= gap_pct;
      prog_data = prog_valid ? (i < 16 ? d[i] : ck) : 8'($urandom);
      cyc();
      if (prog_valid) i++;
    end
    clr();
  endtask

  initial begin
    logic [7:0] d [16];
    logic [7:0] s;
    #10000000 $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [16];
    logic [7:0] s;
    cyc(); cyc(); rst = 0; cyc();
    chk("rst_busy", {7'd0, prog_busy}, 8'd0);
    chk("rst_ready", {7'd0, prog_ready}, 8'd0);
    chk("rst_out", out, 8'h0D);
    rd(4'hE, 8'h04, "read_e");
    for (int i = 0; i < 16; i++) d[i] = 8'(8'h10 + i);
    frame(d, 8'h78, 0);
    chk("good_done", {7'd0, prog_done}, 8'd1);
    chk("good_err", {7'd0, prog_err}, 8'd0);
    chk("good_busy", {7'd0, prog_busy}, 8'd0);
    rd(4'd5, 8'h15, "good_ram5");
    frame(d, 8'h87, 0);
    chk("bad_done", {7'd0, prog_done}, 8'd1);
    chk("bad_err", {7'd0, prog_err}, 8'd1);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'(8'h10 + i), "bad_ram");
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    s = 0;
    foreach (d[i]) s += d[i];
    frame(d, s, 50);
    chk("gap_done", {7'd0, prog_done}, 8'd1);
    chk("gap_err", {7'd0, prog_err}, 8'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), d[i], "gap_ram");
    rd(4'd3, d[3], "pre_abort");
    prog_start = 1; cyc(); prog_start = 0;
    for (int i = 0; i < 3; i++) begin prog_valid = 1; prog_data = 8'(8'h20 + i); cyc(); end
    prog_valid = 1; prog_data = 8'h99; prog_abort = 1; cyc(); clr();
    chk("abort_done", {7'd0, prog_done}, 8'd0);
    chk("abort_err", {7'd0, prog_err}, 8'd1);
    chk("abort_busy", {7'd0, prog_busy}, 8'd0);
    chk("abort_ram3", out, d[3]);
    rd(4'd0, 8'h20, "abort_ram0");
    rd(4'd2, 8'h22, "abort_ram2");
    rd(4'd9, d[9], "mar9");
    prog_start = 1; cyc(); prog_start = 0;
    load = 1; bus = 8'h07; cyc(); load = 0;
    chk("busy_load_ignored", out, d[9]);
    prog_valid = 1; prog_data = 8'h5A; cyc(); clr();
    rst = 1; cyc(); rst = 0;
    chk("midrst_busy", {7'd0, prog_busy}, 8'd0);
    chk("midrst_err", {7'd0, prog_err}, 8'd0);
    chk("midrst_out", out, 8'h5A);
    for (int i = 0; i < 16; i++) d[i] = 8'(8'hC0 + i);
    frame(d, 8'h78, 20);
    chk("after_rst_done", {7'd0, prog_done}, 8'd1);
    chk("after_rst_err", {7'd0, prog_err}, 8'd0);
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(399) == 0;
      prog_start = $urandom_range(99) < 8;
      prog_abort = $urandom_range(99) < 2;
      prog_valid = $urandom_range(99) < 70;
      load = $urandom_range(99) < 20;
      bus = 8'($urandom);
      prog_data = (m_active && q.size() == 16 && $urandom_range(1) == 1) ? qsum() : 8'($urandom);
      cyc();
    end
    clr(); rst = 0; cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
